// File: rtl/mips_mem_bridge.sv
// Memory bridge for the multicycle MIPS core. It maps a 256-byte I/O window (console FIFO and timer) and passes all other accesses to RAM.
// The timer registers and timer_irq exist only when MIPS_MEM_BRIDGE_TIMER_EN is defined.
module mips_mem_bridge #(
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH = 8,
    parameter int          FIFO_AW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    output logic [31:0] ram_adr,
    output logic [31:0] ram_wd,
    output logic        ram_we,
    input  logic [31:0] ram_rd,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        timer_irq
);

    localparam logic [5:0]       OFF_CON_DATA  = 6'h00;
    localparam logic [5:0]       OFF_CON_STAT  = 6'h01;
    localparam logic [5:0]       OFF_TMR_COUNT = 6'h02;
    localparam logic [5:0]       OFF_TMR_CMP   = 6'h03;
    localparam logic [5:0]       OFF_TMR_STAT  = 6'h04;
    localparam logic [FIFO_AW:0] DEPTH_C       = FIFO_DEPTH[FIFO_AW:0];

    logic        io_sel;
    logic [5:0]  off;
    logic        io_we;
    logic [31:0] io_rdata;

    assign io_sel  = (adr[31:8] == IO_BASE[31:8]);
    assign off     = adr[7:2];
    assign io_we   = memwrite & io_sel;
    assign ram_adr = adr;
    assign ram_wd  = writedata;
    assign ram_we  = memwrite & ~io_sel;

    logic [7:0]         mem_q [0:FIFO_DEPTH-1];
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               full, empty, push, pop, push_fire;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign out_valid = ~empty;
    assign push      = io_we & (off == OFF_CON_DATA);
    assign pop       = out_valid & out_ready;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign push_fire = push & (~full | pop);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_fire)
            wr_ptr_d = wr_ptr_q + 1'b1;
        case ({push_fire, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (io_we && off == OFF_CON_STAT && writedata[2])
            overflow_d = 1'b0;
        if (push && !push_fire)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; out_valid and the zeroed pointers hide stale bytes.
    always_ff @(posedge clk) begin
        if (push_fire)
            mem_q[wr_ptr_q] <= writedata[7:0];
    end

`ifdef MIPS_MEM_BRIDGE_TIMER_EN
    logic [31:0] tcount_q, tcount_d;
    logic [31:0] cmp_q, cmp_d;
    logic        match_q, match_d;

    always_comb begin
        tcount_d = tcount_q + 32'd1;
        cmp_d    = cmp_q;
        match_d  = match_q;
        if (io_we && off == OFF_TMR_COUNT)
            tcount_d = writedata;
        if (io_we && off == OFF_TMR_CMP)
            cmp_d = writedata;
        if (io_we && off == OFF_TMR_STAT && writedata[0])
            match_d = 1'b0;
        if (tcount_q == cmp_q)
            match_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcount_q <= '0;
            cmp_q    <= 32'hFFFF_FFFF;
            match_q  <= 1'b0;
        end else begin
            tcount_q <= tcount_d;
            cmp_q    <= cmp_d;
            match_q  <= match_d;
        end
    end

    assign timer_irq = match_q;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        io_rdata = '0;
        case (off)
            OFF_CON_STAT: begin
                io_rdata[8+FIFO_AW:8] = count_q;
                io_rdata[2]           = overflow_q;
                io_rdata[1]           = empty;
                io_rdata[0]           = full;
            end
`ifdef MIPS_MEM_BRIDGE_TIMER_EN
            OFF_TMR_COUNT: io_rdata = tcount_q;
            OFF_TMR_CMP:   io_rdata = cmp_q;
            OFF_TMR_STAT:  io_rdata = {31'b0, match_q};
`endif
            default:       io_rdata = '0;
        endcase
    end

    assign readdata = io_sel ? io_rdata : ram_rd;

endmodule

// File: tb/tb_mips_mem_bridge.sv
// Directed-vector bench for mips_mem_bridge: RAM pass-through, console FIFO boundaries, timer (when enabled), async reset.
// Defining MIPS_MEM_BRIDGE_TIMER_EN for both files also exercises the timer.
module tb_mips_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] adr, writedata, readdata, ram_adr, ram_wd, ram_rd;
    logic        memwrite, ram_we, out_valid, out_ready, timer_irq;
    logic [7:0]  out_data;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] tb_ram [0:255];

    always #5 clk = ~clk;

    mips_mem_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .readdata  (readdata),
        .ram_adr   (ram_adr),
        .ram_wd    (ram_wd),
        .ram_we    (ram_we),
        .ram_rd    (ram_rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .timer_irq (timer_irq)
    );

    // Asynchronous-read RAM behind the bridge
    always @(posedge clk) begin
        if (ram_we)
            tb_ram[ram_adr[9:2]] <= ram_wd;
    end
    assign ram_rd = tb_ram[ram_adr[9:2]];

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        adr       = a;
        writedata = d;
        memwrite  = 1'b1;
        #1;
        check_vec("store ram_we", {31'b0, ram_we}, {31'b0, (a[31:8] != 24'hFFFFFF)});
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        adr      = a;
        memwrite = 1'b0;
        #1;
        check_vec(tag, readdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) tb_ram[i] = 32'h0;
        reset     = 1'b1;
        adr       = 32'hFFFF_FF04;
        writedata = 32'h0;
        memwrite  = 1'b0;
        out_ready = 1'b0;
        #2;
        check_vec("rst out_valid", {31'b0, out_valid}, 32'h0);
        check_vec("rst out_data", {24'b0, out_data}, 32'h0);
        check_vec("rst timer_irq", {31'b0, timer_irq}, 32'h0);
        check_vec("rst con_stat", readdata, 32'h0000_0002);
        @(negedge clk);
        reset = 1'b0;

        // RAM pass-through
        @(negedge clk);
        adr = 32'h40; writedata = 32'h1234_5678; memwrite = 1'b1;
        #1;
        check_vec("ram_we store", {31'b0, ram_we}, 32'h1);
        check_vec("ram_adr", ram_adr, 32'h40);
        @(negedge clk);
        memwrite = 1'b0;
        #1;
        check_vec("ram_we after", {31'b0, ram_we}, 32'h0);
        load("ram load", 32'h40, 32'h1234_5678);

        // Fill, overflow, clear, drain
        for (int i = 0; i < 8; i++) store(32'hFFFF_FF00, 32'h41 + i);
        load("stat full", 32'hFFFF_FF04, 32'h0000_0801);
        store(32'hFFFF_FF00, 32'h49);
        load("stat overflow", 32'hFFFF_FF04, 32'h0000_0805);
        store(32'hFFFF_FF04, 32'h4);
        load("stat ovf clr", 32'hFFFF_FF04, 32'h0000_0801);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_vec("drain valid", {31'b0, out_valid}, 32'h1);
            check_vec("drain data", {24'b0, out_data}, 32'h41 + i);
            @(negedge clk);
        end
        #1;
        check_vec("drained valid", {31'b0, out_valid}, 32'h0);
        out_ready = 1'b0;

        // Push and pop on a full FIFO in the same cycle
        for (int i = 0; i < 8; i++) store(32'hFFFF_FF00, 32'h61 + i);
        @(negedge clk);
        adr = 32'hFFFF_FF00; writedata = 32'h55; memwrite = 1'b1; out_ready = 1'b1;
        #1;
        check_vec("full pp head", {24'b0, out_data}, 32'h61);
        @(negedge clk);
        memwrite = 1'b0; out_ready = 1'b0;
        load("full pp stat", 32'hFFFF_FF04, 32'h0000_0801);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_vec("pp drain", {24'b0, out_data}, (i == 7) ? 32'h55 : 32'h62 + i);
            @(negedge clk);
        end
        #1;
        check_vec("pp drained", {31'b0, out_valid}, 32'h0);

        // Push into an empty FIFO while out_ready is high
        @(negedge clk);
        adr = 32'hFFFF_FF00; writedata = 32'h77; memwrite = 1'b1;
        #1;
        check_vec("empty push valid", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        memwrite = 1'b0;
        #1;
        check_vec("empty push data", {24'b0, out_data}, 32'h77);
        @(negedge clk);
        #1;
        check_vec("empty push pop", {31'b0, out_valid}, 32'h0);
        out_ready = 1'b0;

`ifdef MIPS_MEM_BRIDGE_TIMER_EN
        store(32'hFFFF_FF0C, 32'd20);
        store(32'hFFFF_FF08, 32'd0);
        adr = 32'hFFFF_FF08;
        for (int n = 1; n <= 21; n++) begin
            @(negedge clk);
            #1;
            if (n == 20) begin
                check_vec("tmr count 20", readdata, 32'd20);
                check_vec("tmr irq pre", {31'b0, timer_irq}, 32'h0);
            end
            if (n == 21)
                check_vec("tmr irq match", {31'b0, timer_irq}, 32'h1);
        end
        store(32'hFFFF_FF10, 32'h1);
        #1;
        check_vec("tmr irq clr", {31'b0, timer_irq}, 32'h0);
        store(32'hFFFF_FF08, 32'hFFFF_FFFE);
        adr = 32'hFFFF_FF08;
        #1;
        check_vec("tmr wrap 0", readdata, 32'hFFFF_FFFE);
        @(negedge clk);
        #1;
        check_vec("tmr wrap 1", readdata, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        check_vec("tmr wrap 2", readdata, 32'h0);
`else
        load("no tmr count", 32'hFFFF_FF08, 32'h0);
        store(32'hFFFF_FF0C, 32'h5);
        load("no tmr cmp", 32'hFFFF_FF0C, 32'h0);
        load("no tmr stat", 32'hFFFF_FF10, 32'h0);
        check_vec("no tmr irq", {31'b0, timer_irq}, 32'h0);
`endif

        // Async reset mid-drain with 3 bytes queued
        for (int i = 0; i < 3; i++) store(32'hFFFF_FF00, 32'h31 + i);
`ifdef MIPS_MEM_BRIDGE_TIMER_EN
        store(32'hFFFF_FF08, 32'd0);
        repeat (23) @(negedge clk);
        #1;
        check_vec("pre-rst irq", {31'b0, timer_irq}, 32'h1);
`endif
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check_vec("mid drain head", {24'b0, out_data}, 32'h31);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_vec("async rst valid", {31'b0, out_valid}, 32'h0);
        check_vec("async rst irq", {31'b0, timer_irq}, 32'h0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b0;
        load("post rst stat", 32'hFFFF_FF04, 32'h0000_0002);
`ifdef MIPS_MEM_BRIDGE_TIMER_EN
        load("post rst cmp", 32'hFFFF_FF0C, 32'hFFFF_FFFF);
`else
        load("post rst cmp", 32'hFFFF_FF0C, 32'h0);
`endif

        // Unmapped I/O offset
        load("unmapped rd", 32'hFFFF_FF20, 32'h0);
        store(32'hFFFF_FF20, 32'hDEAD_BEEF);
        load("unmapped stat", 32'hFFFF_FF04, 32'h0000_0002);
        load("unmapped rd2", 32'hFFFF_FF20, 32'h0);
        load("ram intact", 32'h40, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
